binary_to_bcd: RTL and testbench

- Iterative double-dabble converter that sits directly downstream of the sequential multiplier.
- Takes the binary product and produces packed BCD digits for the display/readout stage.
- Uses the same start/finished handshake style as the multiplier, so the multiplier's finished pulse can drive i_start directly.
- Converts one bit per clock.

---
 rtl/binary_to_bcd.sv | 138 +++++++++++++
 tb/tb_binary_to_bcd.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd.sv
// Iterative double-dabble binary to packed-BCD converter. It converts one input bit per clock.
// Latency: o_finished is high BITS cycles after the edge that accepts i_start. One conversion every BITS+1 cycles.
// Backpressure: none. i_start is sampled only while idle. A start while busy is dropped and is not queued.
//
// Ports:
//   i_clock     system clock, rising edge
//   i_reset     synchronous active-high reset; aborts any conversion in flight
//   i_start     start request; sampled only in IDLE
//   i_binary    BITS-wide unsigned value; captured on the accepting edge only
//   o_busy      high while a conversion is in progress
//   o_finished  one-cycle pulse; o_bcd has just been updated
//   o_bcd       4*DIGITS packed BCD result; digit 0 is in bits [3:0]
//   o_overflow  (only with BINARY_TO_BCD_OVERFLOW_EN) input exceeded 10^DIGITS-1
//
// Optional feature macro: BINARY_TO_BCD_OVERFLOW_EN

module binary_to_bcd #(
   parameter int BITS   = 8,
   parameter int DIGITS = 3
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [BITS-1:0]       i_binary,
   output logic                  o_busy,
   output logic                  o_finished,
`ifdef BINARY_TO_BCD_OVERFLOW_EN
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_overflow
`else
   output logic [4*DIGITS-1:0]   o_bcd
`endif
);

   localparam int BW = 4 * DIGITS;          // BCD field width
   localparam int SW = BW + BITS;           // full shift register width
   localparam int CW = $clog2(BITS + 1);    // counter holds BITS..0

   typedef enum logic {
      S_IDLE,
      S_CONVERT
   } state_t;

   state_t          state_q;
   logic [SW-1:0]   shift_q;
   logic [CW-1:0]   cnt_q;
   logic            busy_q;
   logic            finished_q;
   logic [BW-1:0]   bcd_q;

   logic [SW-1:0]   adj_d;       // register after the per-nibble +3 step
   logic [SW-1:0]   shift_d;     // adjusted register shifted left one bit
   logic            last_d;      // this CONVERT edge completes the conversion

`ifdef BINARY_TO_BCD_OVERFLOW_EN
   logic            ovf_sticky_q;
   logic            overflow_q;
   logic            top_bit_d;   // bit leaving the top nibble on this shift
`endif

   // Each BCD nibble is adjusted from its own pre-shift value. The nibbles do not
   // interact, so a +3 in one digit cannot change the test for its neighbour.
   always_comb begin
      adj_d = shift_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (shift_q[BITS + 4*d +: 4] >= 4'd5) begin
            adj_d[BITS + 4*d +: 4] = shift_q[BITS + 4*d +: 4] + 4'd3;
         end
      end
      shift_d = {adj_d[SW-2:0], 1'b0};
      last_d  = (cnt_q == CW'(1));
   end

`ifdef BINARY_TO_BCD_OVERFLOW_EN
   // The register is truncated above the top digit. Any 1 that falls off the top
   // would have become a nonzero higher digit, so it marks a value >= 10^DIGITS.
   assign top_bit_d = adj_d[SW-1];
`endif

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         finished_q   <= 1'b0;
         bcd_q        <= '0;
`ifdef BINARY_TO_BCD_OVERFLOW_EN
         ovf_sticky_q <= 1'b0;
         overflow_q   <= 1'b0;
`endif
      end else begin
         finished_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  shift_q      <= {{BW{1'b0}}, i_binary};
                  cnt_q        <= CW'(BITS);
                  busy_q       <= 1'b1;
                  state_q      <= S_CONVERT;
`ifdef BINARY_TO_BCD_OVERFLOW_EN
                  ovf_sticky_q <= 1'b0;
`endif
               end
            end
            S_CONVERT: begin
               shift_q      <= shift_d;
               cnt_q        <= cnt_q - CW'(1);
`ifdef BINARY_TO_BCD_OVERFLOW_EN
               ovf_sticky_q <= ovf_sticky_q | top_bit_d;
`endif
               if (last_d) begin
                  // The result is published all at once, so o_bcd never shows a partial value.
                  bcd_q      <= shift_d[SW-1:BITS];
                  finished_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
`ifdef BINARY_TO_BCD_OVERFLOW_EN
                  overflow_q <= ovf_sticky_q | top_bit_d;
`endif
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy     = busy_q;
   assign o_finished = finished_q;
   assign o_bcd      = bcd_q;
`ifdef BINARY_TO_BCD_OVERFLOW_EN
   assign o_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_binary_to_bcd.sv
module tb_binary_to_bcd;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_binary = 8'd0;
   logic        o_busy, o_finished, o_busy2, o_finished2;
   logic [11:0] o_bcd;
   logic [7:0]  o_bcd2;
`ifdef BINARY_TO_BCD_OVERFLOW_EN
   logic        o_overflow, o_overflow2;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clock = ~i_clock;

   binary_to_bcd #(.BITS(8), .DIGITS(3)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_binary(i_binary),
      .o_busy(o_busy), .o_finished(o_finished),
`ifdef BINARY_TO_BCD_OVERFLOW_EN
      .o_bcd(o_bcd), .o_overflow(o_overflow)
`else
      .o_bcd(o_bcd)
`endif
   );

   // Two-digit instance on the same inputs, used for the wrap-around and overflow cases.
   binary_to_bcd #(.BITS(8), .DIGITS(2)) dut2 (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_binary(i_binary),
      .o_busy(o_busy2), .o_finished(o_finished2),
`ifdef BINARY_TO_BCD_OVERFLOW_EN
      .o_bcd(o_bcd2), .o_overflow(o_overflow2)
`else
      .o_bcd(o_bcd2)
`endif
   );

   // Reference: decimal digits by plain division, keeping only the low 'digits' digits.
   function automatic logic [11:0] bcd_model(input int v, input int digits);
      logic [11:0] r;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < digits; k++) begin
         r[4*k +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   // Call at a negedge. Starts one conversion and returns at the negedge where o_finished is seen.
   // lat is the number of edges after the accepting edge, or -1 on timeout.
   // busy_err counts cycles where o_busy disagreed with "in progress".
   task automatic do_conv(input logic [7:0] v, output int lat, output int busy_err);
      i_start  = 1'b1;
      i_binary = v;
      @(posedge i_clock);
      #1;
      i_start  = 1'b0;
      i_binary = 8'($urandom);
      lat      = -1;
      busy_err = 0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge i_clock);
         @(negedge i_clock);
         if (o_finished) begin
            lat = k;
            if (o_busy) busy_err++;
            break;
         end
         if (!o_busy) busy_err++;
      end
   endtask

   task automatic test_reset;
      i_reset = 1'b1;
      i_start = 1'b1;
      repeat (2) @(posedge i_clock);
      @(negedge i_clock);
      i_start = 1'b0;
      n_checks++;
      if (o_busy !== 1'b0 || o_finished !== 1'b0 || o_bcd !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b fin=%b bcd=%h, want 0 0 000", o_busy, o_finished, o_bcd);
      end
      n_checks++;
      if (o_bcd2 !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state_d2: bcd=%h want 00", o_bcd2);
      end
      i_reset = 1'b0;
      @(negedge i_clock);
      n_checks++;
      if (o_busy !== 1'b0 || o_finished !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b fin=%b want 0 0", o_busy, o_finished);
      end
   endtask

   task automatic test_basic;
      int lat, berr;
      do_conv(8'd143, lat, berr);
      n_checks++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL basic_latency: got %0d want 8", lat);
      end
      n_checks++;
      if (o_bcd !== 12'h143) begin
         n_fail++;
         $display("FAIL basic_bcd: got %h want 143", o_bcd);
      end
      n_checks++;
      if (berr !== 0) begin
         n_fail++;
         $display("FAIL basic_busy: %0d bad busy cycles, want 0", berr);
      end
      @(negedge i_clock);
      n_checks++;
      if (o_finished !== 1'b0 || o_bcd !== 12'h143) begin
         n_fail++;
         $display("FAIL basic_hold: fin=%b bcd=%h want 0 143", o_finished, o_bcd);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  vals [3];
      logic [11:0] exp_bcd [3];
      int lat, berr;
      vals    = '{8'd0, 8'd55, 8'd255};
      exp_bcd = '{12'h000, 12'h055, 12'h255};
      // Each call starts on the negedge that saw the previous o_finished.
      for (int i = 0; i < 3; i++) begin
         do_conv(vals[i], lat, berr);
         n_checks++;
         if (lat !== 8 || berr !== 0) begin
            n_fail++;
            $display("FAIL b2b_timing[%0d]: lat=%0d busy_err=%0d want 8 0", i, lat, berr);
         end
         n_checks++;
         if (o_bcd !== exp_bcd[i]) begin
            n_fail++;
            $display("FAIL b2b_bcd[%0d]: got %h want %h", i, o_bcd, exp_bcd[i]);
         end
      end
      @(negedge i_clock);
      n_checks++;
      if (o_finished !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_pulse_width: fin=%b want 0", o_finished);
      end
   endtask

   task automatic test_ignore_start;
      int fin_cnt, first_e;
      i_start  = 1'b1;
      i_binary = 8'd130;
      @(posedge i_clock);             // accepting edge N
      #1 i_start = 1'b0;
      repeat (2) @(posedge i_clock);  // N+1, N+2
      @(negedge i_clock);
      i_start  = 1'b1;
      i_binary = 8'd50;
      @(posedge i_clock);             // N+3, start must be ignored
      #1 i_start = 1'b0;
      fin_cnt = 0;
      first_e = -1;
      for (int e = 4; e <= 25; e++) begin
         @(posedge i_clock);
         @(negedge i_clock);
         if (o_finished) begin
            fin_cnt++;
            if (first_e < 0) first_e = e;
         end
      end
      n_checks++;
      if (fin_cnt !== 1 || first_e !== 8) begin
         n_fail++;
         $display("FAIL ignore_start_pulses: count=%0d first_edge=%0d want 1 8", fin_cnt, first_e);
      end
      n_checks++;
      if (o_bcd !== 12'h130) begin
         n_fail++;
         $display("FAIL ignore_start_bcd: got %h want 130", o_bcd);
      end
   endtask

   task automatic test_reset_mid;
      int fin_cnt, lat, berr;
      i_start  = 1'b1;
      i_binary = 8'd200;
      @(posedge i_clock);
      #1 i_start = 1'b0;
      repeat (3) @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b1;
      @(posedge i_clock);
      @(negedge i_clock);
      i_reset = 1'b0;
      n_checks++;
      if (o_busy !== 1'b0 || o_bcd !== 12'h000 || o_finished !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_state: busy=%b bcd=%h fin=%b want 0 000 0", o_busy, o_bcd, o_finished);
      end
      fin_cnt = 0;
      for (int e = 0; e < 12; e++) begin
         @(negedge i_clock);
         if (o_finished) fin_cnt++;
      end
      n_checks++;
      if (fin_cnt !== 0) begin
         n_fail++;
         $display("FAIL reset_mid_no_finish: %0d pulses want 0", fin_cnt);
      end
      do_conv(8'd99, lat, berr);
      n_checks++;
      if (lat !== 8 || o_bcd !== 12'h099) begin
         n_fail++;
         $display("FAIL reset_mid_restart: lat=%0d bcd=%h want 8 099", lat, o_bcd);
      end
   endtask

   task automatic test_two_digit;
      logic [7:0] vals [3];
      logic [7:0] exp_bcd [3];
      logic       exp_ovf [3];
      int lat, berr;
      vals    = '{8'd99, 8'd100, 8'd42};
      exp_bcd = '{8'h99, 8'h00, 8'h42};
      exp_ovf = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         do_conv(vals[i], lat, berr);
         n_checks++;
         if (o_finished2 !== 1'b1 || o_bcd2 !== exp_bcd[i]) begin
            n_fail++;
            $display("FAIL two_digit_bcd[%0d]: fin=%b bcd=%h want 1 %h", i, o_finished2, o_bcd2, exp_bcd[i]);
         end
`ifdef BINARY_TO_BCD_OVERFLOW_EN
         n_checks++;
         if (o_overflow2 !== exp_ovf[i]) begin
            n_fail++;
            $display("FAIL two_digit_ovf[%0d]: got %b want %b", i, o_overflow2, exp_ovf[i]);
         end
`else
         if (exp_ovf[i] === 1'bx) $display("unexpected x");
`endif
      end
   endtask

   task automatic test_random;
      int lat, berr, v;
      logic [11:0] m2;
      for (int i = 0; i < 25; i++) begin
         v = int'($urandom_range(0, 255));
         do_conv(8'(v), lat, berr);
         n_checks++;
         if (lat !== 8 || berr !== 0 || o_bcd !== bcd_model(v, 3)) begin
            n_fail++;
            $display("FAIL random_d3 v=%0d: lat=%0d busy_err=%0d bcd=%h want 8 0 %h",
                     v, lat, berr, o_bcd, bcd_model(v, 3));
         end
         m2 = bcd_model(v, 2);
         n_checks++;
         if (o_bcd2 !== m2[7:0]) begin
            n_fail++;
            $display("FAIL random_d2 v=%0d: bcd=%h want %h", v, o_bcd2, m2[7:0]);
         end
`ifdef BINARY_TO_BCD_OVERFLOW_EN
         n_checks++;
         if (o_overflow2 !== (v > 99) || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL random_ovf v=%0d: ovf2=%b ovf3=%b want %b 0", v, o_overflow2, o_overflow, (v > 99));
         end
`endif
      end
   endtask

   initial begin
      @(negedge i_clock);
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_start();
      test_reset_mid();
      test_two_digit();
      test_random();
      repeat (2) @(negedge i_clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so a stuck bench still terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule
